// File: rtl/star_scanner.sv
// Raster scanner: walks the frame memory one pixel per clock and stops on each
// star-coloured pixel, reporting its coordinates until the frame is exhausted.
module star_scanner #(
  parameter int                 xSz         = 8,
  parameter int                 ySz         = 7,
  parameter int                 colSz       = 3,
  parameter int                 X_MAX       = 160,
  parameter int                 Y_MAX       = 120,
  parameter logic [colSz-1:0]   STAR_COLOUR = 3'b111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             ack,
  input  logic [colSz-1:0] pixIn,
  output logic [14:0]      addr,
  output logic [xSz-1:0]   xOut,
  output logic [ySz-1:0]   yOut,
  output logic             starFound,
  output logic             scanDone
);

  typedef enum logic [1:0] {IDLE, SCAN, FOUND, DONE} state_t;

  localparam logic [xSz-1:0] X_LAST = xSz'(X_MAX - 1);
  localparam logic [ySz-1:0] Y_LAST = ySz'(Y_MAX - 1);

  state_t         state, state_next;
  logic [xSz-1:0] xs, xd, rx;
  logic [ySz-1:0] ys, yd, ry;
  logic           iss;       // counters hold an address still to be issued
  logic           vld_d;     // pixIn belongs to (xd, yd)
  logic           r_last;    // reported star was the final pixel of the frame

  logic hit, d_last, s_last;
  logic start, resume, capture;

  assign hit    = vld_d && (pixIn == STAR_COLOUR);
  assign d_last = (xd == X_LAST) && (yd == Y_LAST);
  assign s_last = (xs == X_LAST) && (ys == Y_LAST);

  assign addr = 15'(ys) * 15'(X_MAX) + 15'(xs);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    resume     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (go) begin
          state_next = SCAN;
          start      = 1'b1;
        end
      end
      SCAN: begin
        if (hit) begin
          state_next = FOUND;
          capture    = 1'b1;
        end else if (vld_d && d_last) begin
          state_next = DONE;
        end
      end
      FOUND: begin
        // ack takes priority; go is ignored here
        if (ack) begin
          if (r_last) begin
            state_next = DONE;
          end else begin
            state_next = SCAN;
            resume     = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign starFound = (state == FOUND);
  assign scanDone  = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments with the synchronous
  // reset tested first, so every register clears on the same edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xs     <= '0;
      ys     <= '0;
      xd     <= '0;
      yd     <= '0;
      rx     <= '0;
      ry     <= '0;
      r_last <= 1'b0;
      iss    <= 1'b0;
      vld_d  <= 1'b0;
      xOut   <= '0;
      yOut   <= '0;
    end else if (start) begin
      xs    <= '0;
      ys    <= '0;
      iss   <= 1'b1;
      vld_d <= 1'b0;
    end else if (resume) begin
      xs    <= rx;
      ys    <= ry;
      iss   <= 1'b1;
      vld_d <= 1'b0;
    end else if (capture) begin
      xOut   <= xd;
      yOut   <= yd;
      r_last <= d_last;
      if (xd == X_LAST) begin
        rx <= '0;
        ry <= yd + 1'b1;
      end else begin
        rx <= xd + 1'b1;
        ry <= yd;
      end
      // the read issued this cycle is dropped; scanning restarts from rx/ry
      iss   <= 1'b0;
      vld_d <= 1'b0;
    end else if (state == SCAN) begin
      vld_d <= iss;
      if (iss) begin
        xd <= xs;
        yd <= ys;
        if (s_last) begin
          iss <= 1'b0;
        end else if (xs == X_LAST) begin
          xs <= '0;
          ys <= ys + 1'b1;
        end else begin
          xs <= xs + 1'b1;
        end
      end
    end else begin
      iss   <= 1'b0;
      vld_d <= 1'b0;
    end
  end

endmodule
